// File: rtl/led_cnt_pkg.sv
// Shared types and helpers for the multi-channel LED blink/one-shot controller.
package led_cnt_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_ONESHOT = 2'd3
    } mode_e;

    localparam int DIV_W_DEF = 12;
    localparam int PWM_W_DEF = 8;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_cnt_ch.sv
// One LED channel: divider/mode/phase registers, event pulse and optional PWM
// brightness gate (enabled by the LED_CNT_PWM_EN macro).
module led_cnt_ch
    import led_cnt_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = 499,
    parameter int PWM_W   = PWM_W_DEF
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] div_i,
    input  mode_e            mode_i,
`ifdef LED_CNT_PWM_EN
    input  logic [PWM_W-1:0] bright_i,
    input  logic [PWM_W-1:0] pwm_cnt_i,
`endif
    output logic             phase_o,
    output logic             led_o,
    output logic             evt_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic             phase_q, phase_d;
    logic             evt_q, evt_d;
    logic             running;

    // A one-shot only counts while its phase is still high.
    assign running = (mode_q == LED_BLINK) || ((mode_q == LED_ONESHOT) && phase_q);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        div_d   = div_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        evt_d   = 1'b0;
        if (wr_i) begin
            div_d   = div_i;
            mode_d  = mode_i;
            cnt_d   = '0;
            phase_d = (mode_i == LED_ON) || (mode_i == LED_ONESHOT);
        end else if (tick_i && running) begin
            if (cnt_q >= div_q) begin
                cnt_d = '0;
                if (mode_q == LED_BLINK) begin
                    phase_d = ~phase_q;
                    evt_d   = ~phase_q;
                end else begin
                    phase_d = 1'b0;
                    evt_d   = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (rst) begin
            div_q   <= DIV_W'(DIV_RST);
            cnt_q   <= '0;
            mode_q  <= LED_BLINK;
            phase_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            evt_q   <= evt_d;
        end
    end

    assign phase_o = phase_q;
    assign evt_o   = evt_q;

`ifdef LED_CNT_PWM_EN
    logic [PWM_W-1:0] bright_q;
    logic             led_q;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            bright_q <= '1;
            led_q    <= 1'b0;
        end else begin
            if (wr_i) begin
                bright_q <= bright_i;
            end
            led_q <= phase_q & (pwm_cnt_i < bright_q);
        end
    end

    assign led_o = led_q;
`else
    assign led_o = phase_q;
`endif

endmodule

// File: rtl/led_cnt_mc.sv
// Multi-channel LED controller top: shared tick prescaler, write decode and
// NUM_CH channel instances. Define LED_CNT_PWM_EN for per-channel PWM brightness.
module led_cnt_mc
    import led_cnt_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = DIV_W_DEF,
    parameter int PRESCALE = 100000,
    parameter int DIV_RST  = 499,
    parameter int PWM_W    = PWM_W_DEF
) (
    input  logic                      clk100,
    input  logic                      rst,
    input  logic                      wren_i,
    input  logic [sel_w(NUM_CH)-1:0]  ch_sel_i,
    input  logic [DIV_W-1:0]          div_i,
    input  logic [1:0]                mode_i,
    input  logic [PWM_W-1:0]          bright_i,
    output logic [NUM_CH-1:0]         led_int_o,
    output logic [NUM_CH-1:0]         led_o,
    output logic [NUM_CH-1:0]         evt_o
);

    localparam int SEL_W = sel_w(NUM_CH);
    localparam int PRE_W = $clog2(PRESCALE);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;

    always_comb begin
        tick_d = (pre_q == PRE_W'(PRESCALE - 1));
        pre_d  = tick_d ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

`ifdef LED_CNT_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end
`else
    logic unused_bright;
    assign unused_bright = ^bright_i;
`endif

    // An out-of-range select matches no channel, so the write is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = wren_i && (ch_sel_i == SEL_W'(i));

        led_cnt_ch #(
            .DIV_W  (DIV_W),
            .DIV_RST(DIV_RST),
            .PWM_W  (PWM_W)
        ) u_ch (
            .clk100   (clk100),
            .rst      (rst),
            .tick_i   (tick_q),
            .wr_i     (wr),
            .div_i    (div_i),
            .mode_i   (mode_e'(mode_i)),
`ifdef LED_CNT_PWM_EN
            .bright_i (bright_i),
            .pwm_cnt_i(pwm_cnt_q),
`endif
            .phase_o  (led_int_o[i]),
            .led_o    (led_o[i]),
            .evt_o    (evt_o[i])
        );
    end

endmodule

// File: tb/tb_led_cnt_mc.sv
// Self-checking bench for led_cnt_mc: hand-derived vector table, corner sequences
// and randomized writes against a tick/remaining-count reference model.
module tb_led_cnt_mc;
    import led_cnt_pkg::*;

    localparam int NUM_CH   = 4;
    localparam int DIV_W    = 4;
    localparam int PRESCALE = 4;
    localparam int DIV_RST  = 3;
    localparam int PWM_W    = 8;

    logic              clk100 = 1'b0;
    logic              rst    = 1'b1;
    logic              wren_i = 1'b0;
    logic [1:0]        ch_sel_i = '0;
    logic [DIV_W-1:0]  div_i  = '0;
    logic [1:0]        mode_i = '0;
    logic [PWM_W-1:0]  bright_i = '1;
    logic [NUM_CH-1:0] led_int_o, led_o, evt_o;

    int n_checks = 0;
    int n_errors = 0;

    led_cnt_mc #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .PRESCALE(PRESCALE),
        .DIV_RST(DIV_RST), .PWM_W(PWM_W)
    ) dut (
        .clk100   (clk100),
        .rst      (rst),
        .wren_i   (wren_i),
        .ch_sel_i (ch_sel_i),
        .div_i    (div_i),
        .mode_i   (mode_i),
        .bright_i (bright_i),
        .led_int_o(led_int_o),
        .led_o    (led_o),
        .evt_o    (evt_o)
    );

    always #5 clk100 = ~clk100;

    // Reference model: ticks derived from edge count, channels track ticks remaining.
    int m_edges;
    int m_div[NUM_CH];
    int m_mode[NUM_CH];
    int m_remain[NUM_CH];
    int m_bright[NUM_CH];
    bit m_phase[NUM_CH];
    bit m_evt[NUM_CH];
    bit m_led[NUM_CH];

    function automatic void model_reset();
        m_edges = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]    = DIV_RST;
            m_mode[i]   = 2;
            m_remain[i] = DIV_RST + 1;
            m_bright[i] = 255;
            m_phase[i]  = 1'b0;
            m_evt[i]    = 1'b0;
            m_led[i]    = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        bit tick;
        tick = (m_edges >= PRESCALE) && (m_edges % PRESCALE == 0);
        for (int i = 0; i < NUM_CH; i++) begin
            m_led[i] = m_phase[i] && ((m_edges % 256) < m_bright[i]);
            m_evt[i] = 1'b0;
            if (wren_i && int'(ch_sel_i) == i) begin
                m_div[i]    = int'(div_i);
                m_mode[i]   = int'(mode_i);
                m_bright[i] = int'(bright_i);
                m_phase[i]  = (mode_i == 2'd1) || (mode_i == 2'd3);
                m_remain[i] = int'(div_i) + 1;
            end else if (tick && (m_mode[i] == 2 || (m_mode[i] == 3 && m_phase[i]))) begin
                m_remain[i]--;
                if (m_remain[i] == 0) begin
                    m_remain[i] = m_div[i] + 1;
                    if (m_mode[i] == 2) begin
                        m_phase[i] = !m_phase[i];
                        m_evt[i]   = m_phase[i];
                    end else begin
                        m_phase[i] = 1'b0;
                        m_evt[i]   = 1'b1;
                    end
                end
            end
        end
        m_edges++;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [NUM_CH-1:0] e_int, e_evt, e_led;
        for (int i = 0; i < NUM_CH; i++) begin
            e_int[i] = m_phase[i];
            e_evt[i] = m_evt[i];
`ifdef LED_CNT_PWM_EN
            e_led[i] = m_led[i];
`else
            e_led[i] = m_phase[i];
`endif
        end
        check({tag, " led_int"}, 32'(led_int_o), 32'(e_int));
        check({tag, " evt"},     32'(evt_o),     32'(e_evt));
        check({tag, " led"},     32'(led_o),     32'(e_led));
    endtask

    task automatic clk_edge();
        @(posedge clk100);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        wren_i = 1'b0;
        repeat (2) @(posedge clk100);
        #1;
        check("reset led_int", 32'(led_int_o), 32'h0);
        check("reset evt",     32'(evt_o),     32'h0);
        check("reset led",     32'(led_o),     32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive_write(input int sel, input int div, input logic [1:0] mode, input int bright);
        wren_i   = 1'b1;
        ch_sel_i = 2'(sel);
        div_i    = DIV_W'(div);
        mode_i   = mode;
        bright_i = PWM_W'(bright);
    endtask

    typedef struct {
        int          sel;
        int          div;
        mode_e       mode;
        int          edges;
        logic [3:0]  exp_int;
        int          exp_evts;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int evts;
        int hi_led, hi_int;

        // Write lands on edge 1 after reset; ticks act on edges 5, 9, 13, 17...;
        // untouched channels (BLINK, div 3) first rise on edge 17.
        vecs[0] = '{0, 5, LED_ON,      3,  4'b0001, 0};
        vecs[1] = '{1, 0, LED_BLINK,   13, 4'b0010, 2};
        vecs[2] = '{1, 0, LED_BLINK,   10, 4'b0000, 1};
        vecs[3] = '{2, 2, LED_ONESHOT, 12, 4'b0100, 0};
        vecs[4] = '{2, 2, LED_ONESHOT, 13, 4'b0000, 1};
        vecs[5] = '{3, 1, LED_BLINK,   16, 4'b1000, 1};
        vecs[6] = '{3, 1, LED_BLINK,   17, 4'b0111, 1};
        vecs[7] = '{0, 0, LED_OFF,     17, 4'b1110, 0};
        vecs[8] = '{2, 0, LED_ONESHOT, 5,  4'b0000, 1};
        vecs[9] = '{1, 9, LED_ON,      20, 4'b1111, 0};

        for (int v = 0; v < 10; v++) begin
            do_reset();
            drive_write(vecs[v].sel, vecs[v].div, vecs[v].mode, 255);
            evts = 0;
            for (int e = 1; e <= vecs[v].edges; e++) begin
                clk_edge();
                if (e == 1) wren_i = 1'b0;
                evts += int'(evt_o[vecs[v].sel]);
            end
            check($sformatf("vec%0d led_int", v), 32'(led_int_o), 32'(vecs[v].exp_int));
            check($sformatf("vec%0d evt_count", v), 32'(evts), 32'(vecs[v].exp_evts));
        end

        // Default blink after reset: first rise on edge 17 with event, fall on 33 without.
        do_reset();
        repeat (16) clk_edge();
        check("dflt pre-rise", 32'(led_int_o), 32'h0);
        clk_edge();
        check("dflt rise", 32'(led_int_o), 32'hf);
        check("dflt rise evt", 32'(evt_o), 32'hf);
        clk_edge();
        check("dflt evt one-cycle", 32'(evt_o), 32'h0);
        repeat (15) clk_edge();
        check("dflt fall", 32'(led_int_o), 32'h0);
        check("dflt fall evt", 32'(evt_o), 32'h0);

        // Write on the tick edge wins: cleared count, no toggle until edge 9.
        do_reset();
        repeat (4) clk_edge();
        drive_write(0, 0, 2'd2, 255);
        clk_edge();
        wren_i = 1'b0;
        check("coinc no toggle", 32'(led_int_o[0]), 32'h0);
        check("coinc no evt",    32'(evt_o[0]),     32'h0);
        repeat (3) clk_edge();
        check("coinc hold", 32'(led_int_o[0]), 32'h0);
        clk_edge();
        check("coinc toggle",  32'(led_int_o[0]), 32'h1);
        check("coinc evt",     32'(evt_o[0]),     32'h1);

        // Reset asserted mid-oneshot clears outputs without a clock edge.
        do_reset();
        drive_write(2, 2, 2'd3, 255);
        clk_edge();
        wren_i = 1'b0;
        repeat (5) clk_edge();
        check("oneshot active", 32'(led_int_o), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check("async rst led_int", 32'(led_int_o), 32'h0);
        check("async rst evt",     32'(evt_o),     32'h0);
        check("async rst led",     32'(led_o),     32'h0);
        repeat (2) @(posedge clk100);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (17) clk_edge();
        check("post rst blink", 32'(led_int_o), 32'hf);
        check("post rst evt",   32'(evt_o),     32'hf);

`ifdef LED_CNT_PWM_EN
        do_reset();
        drive_write(3, 0, 2'd1, 64);
        clk_edge();
        wren_i = 1'b0;
        hi_led = 0;
        hi_int = 0;
        for (int c = 0; c < 256; c++) begin
            clk_edge();
            hi_led += int'(led_o[3]);
            hi_int += int'(led_int_o[3]);
        end
        check("pwm duty", 32'(hi_led), 32'd64);
        check("pwm raw",  32'(hi_int), 32'd256);
`else
        hi_led = 0;
        hi_int = 0;
`endif

        // Randomized writes checked cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            wren_i   = ($urandom_range(0, 7) == 0);
            ch_sel_i = 2'($urandom_range(0, 3));
            div_i    = DIV_W'($urandom_range(0, 5));
            mode_i   = 2'($urandom_range(0, 3));
            bright_i = PWM_W'($urandom);
            clk_edge();
            compare_model($sformatf("rand c%0d", c));
        end
        wren_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
